clk_en_seq: RTL and testbench

CLK_EN_SEQ -- requirements
Module: clk_en_seq

---
 rtl/clk_en_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_clk_en_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_seq.sv
// clk_en_seq: PLL-lock gated clock-enable and reset sequencer.
// A synchronised lock indication is debounced, downstream channel resets are
// released one by one, and then per-channel divided clock-enable strobes run
// phase-aligned until lock is lost.
// Optional build macro CLK_EN_SEQ_LOSS_CNT_EN adds the loss_cnt[7:0] output.
module clk_en_seq #(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 8,
    parameter int LOCK_CNT = 1024,
    parameter int REL_GAP  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    lost_clr,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic                    lock_ok,
    output logic                    lock_lost
`ifdef CLK_EN_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]              loss_cnt
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        DEBOUNCE  = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DB_W    = $clog2(LOCK_CNT + 1);
    localparam int REL_TOT = NUM_CH * REL_GAP;
    localparam int REL_W   = $clog2(REL_TOT + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(LOCK_CNT - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_TOT - 1);

    logic              meta_q;
    logic              lk_s_q;
    state_e            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic [DIV_W-1:0]  ratio_in  [NUM_CH];
    logic [DIV_W-1:0]  div_cnt_q [NUM_CH];
    logic [DIV_W-1:0]  div_cnt_d [NUM_CH];
    logic [DIV_W-1:0]  shadow_q  [NUM_CH];
    logic [DIV_W-1:0]  shadow_d  [NUM_CH];
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
    logic              lock_ok_q, lock_ok_d;
    logic              lock_lost_q, lock_lost_d;
    logic              run_entry;
    logic              lost_set;

    // Terminal count of a period: ratio 0 behaves like ratio 1.
    function automatic logic [DIV_W-1:0] term_cnt(input logic [DIV_W-1:0] r);
        return (r == '0) ? '0 : r - 1'b1;
    endfunction

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            lk_s_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep both flops sampling the pre-edge values, forming a true two-stage chain.
            meta_q <= pll_locked;
            lk_s_q <= meta_q;
        end
    end

    // Next-state logic: debounce lock, stagger releases, fall back on any loss.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d  = DEBOUNCE;
                    db_cnt_d = '0;
                end
            end
            DEBOUNCE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASE;
                    rel_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            RELEASE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (rel_cnt_q == REL_LAST) begin
                    state_d = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            RUN: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // State and sequencing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            db_cnt_q  <= '0;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    assign run_entry = (state_d == RUN) && (state_q != RUN);
    assign lost_set  = (state_q == RUN) && !lk_s_q;

    // Status outputs decoded from the next state so they are registered and glitch-free.
    always_comb begin
        ch_rst_n_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_d == RUN) ||
                ((state_d == RELEASE) && (int'(rel_cnt_d) >= i * REL_GAP))) begin
                ch_rst_n_d[i] = 1'b1;
            end
        end
        lock_ok_d   = (state_d == RUN);
        // A set in the same cycle as a clear wins.
        lock_lost_d = lost_set | (lock_lost_q & ~lost_clr);
    end

    // Per-channel dividers: counters held at zero outside RUN, ratio latched per period.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ratio_in[i]  = div_ratio[i*DIV_W +: DIV_W];
            div_cnt_d[i] = '0;
            shadow_d[i]  = shadow_q[i];
            if (run_entry) begin
                shadow_d[i] = ratio_in[i];
            end else if (state_d == RUN) begin
                if (div_cnt_q[i] == term_cnt(shadow_q[i])) begin
                    shadow_d[i] = ratio_in[i];
                end else begin
                    div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
                end
            end
            ce_d[i] = (state_d == RUN) && (div_cnt_d[i] == term_cnt(shadow_d[i]));
        end
    end

    // Divider counters and ratio shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-channel arrays are a few flops each, not a RAM, so resetting them is cheap and required.
            for (int i = 0; i < NUM_CH; i++) begin
                div_cnt_q[i] <= '0;
                shadow_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_cnt_q[i] <= div_cnt_d[i];
                shadow_q[i]  <= shadow_d[i];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q        <= '0;
            ch_rst_n_q  <= '0;
            lock_ok_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            ce_q        <= ce_d;
            ch_rst_n_q  <= ch_rst_n_d;
            lock_ok_q   <= lock_ok_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign ce        = ce_q;
    assign ch_rst_n  = ch_rst_n_q;
    assign lock_ok   = lock_ok_q;
    assign lock_lost = lock_lost_q;

`ifdef CLK_EN_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of RUN exits; a clear coinciding with a new loss leaves 1.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lost_clr) begin
            loss_cnt_d = lost_set ? 8'd1 : 8'd0;
        end else if (lost_set && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    // Loss counter not built: no extra port and no extra state.
`endif

endmodule

// File: tb/tb_clk_en_seq.sv
// Bench for clk_en_seq: a lock-history reference model checked every cycle,
// directed timing checks with literal expectations, then randomized stimulus.
// Define CLK_EN_SEQ_LOSS_CNT_EN to also cover the loss counter.
module tb_clk_en_seq;

    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 8;
    localparam int LOCK_CNT = 16;
    localparam int REL_GAP  = 4;
    // Consecutive edges that saw the synchronised lock high before each milestone:
    // the first such edge enters DEBOUNCE, LOCK_CNT more reach RELEASE.
    localparam int REL_N = LOCK_CNT + 1;
    localparam int RUN_N = REL_N + NUM_CH * REL_GAP;

    logic                    clk;
    logic                    rst_n;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    lost_clr;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       ch_rst_n;
    logic                    lock_ok;
    logic                    lock_lost;
`ifdef CLK_EN_SEQ_LOSS_CNT_EN
    logic [7:0]              loss_cnt;
`endif

    clk_en_seq #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .LOCK_CNT(LOCK_CNT),
        .REL_GAP (REL_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .div_ratio (div_ratio),
        .lost_clr  (lost_clr),
        .ce        (ce),
        .ch_rst_n  (ch_rst_n),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
`ifdef CLK_EN_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic              h1, h2;     // pll samples taken one and two edges ago
    int                n;          // consecutive edges that saw synchronised lock high
    logic [NUM_CH-1:0] m_ce, m_rst;
    logic              m_ok, m_lost;
    int                m_loss;
    int                p_start [NUM_CH];
    int                p_len   [NUM_CH];

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic lk;
        logic lost;
        int   j;
        if (!rst_n) begin
            h1 = 1'b0; h2 = 1'b0; n = 0;
            m_ce = '0; m_rst = '0; m_ok = 1'b0; m_lost = 1'b0; m_loss = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                p_start[i] = 0;
                p_len[i]   = 1;
            end
        end else begin
            lk = h2;
            h2 = h1;
            h1 = pll_locked;
            lost = (n >= RUN_N) && !lk;
            n = lk ? ((n < 1000000) ? n + 1 : n) : 0;
            for (int i = 0; i < NUM_CH; i++) m_rst[i] = (n >= REL_N + i * REL_GAP);
            m_ok = (n >= RUN_N);
            if (m_ok) begin
                j = n - RUN_N;   // index of this RUN cycle, 0 = first
                for (int i = 0; i < NUM_CH; i++) begin
                    if (j == 0 || m_ce[i]) begin
                        p_start[i] = j;
                        p_len[i]   = eff(int'(div_ratio[i*DIV_W +: DIV_W]));
                    end
                    m_ce[i] = (j == p_start[i] + p_len[i] - 1);
                end
            end else begin
                m_ce = '0;
            end
            m_lost = lost | (m_lost & !lost_clr);
            if (lost_clr) m_loss = lost ? 1 : 0;
            else if (lost && m_loss < 255) m_loss = m_loss + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("model_ce",        32'(ce),        32'(m_ce));
            check("model_ch_rst_n",  32'(ch_rst_n),  32'(m_rst));
            check("model_lock_ok",   32'(lock_ok),   32'(m_ok));
            check("model_lock_lost", 32'(lock_lost), 32'(m_lost));
`ifdef CLK_EN_SEQ_LOSS_CNT_EN
            check("model_loss_cnt",  32'(loss_cnt),  32'(m_loss));
`endif
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return ch_rst_n[0];
            1:       return ch_rst_n[1];
            2:       return lock_ok;
            default: return ce[0];
        endcase
    endfunction

    // Cycles (negedges) until the selected output is seen high; -1 on timeout.
    task automatic wait_high(input int sel, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = -1;
        for (int k = 1; k <= 200 && !hit; k++) begin
            @(negedge clk);
            if (sel_sig(sel)) begin
                hit    = 1'b1;
                cycles = k;
            end
        end
    endtask

    task automatic check_all_low(input string name);
        check({name, "_ce"},        32'(ce),        32'd0);
        check({name, "_ch_rst_n"},  32'(ch_rst_n),  32'd0);
        check({name, "_lock_ok"},   32'(lock_ok),   32'd0);
        check({name, "_lock_lost"}, 32'(lock_lost), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int cyc;
        int hold;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        lost_clr   = 1'b0;
        div_ratio  = {8'd1, 8'd4};
        repeat (3) @(negedge clk);
        check_all_low("reset");
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Lock-up timing: 2 sync edges, 1 edge into DEBOUNCE, LOCK_CNT debounce edges,
        // observed at the following negedge.
        pll_locked = 1'b1;
        wait_high(0, cyc); check("rel0_delay", 32'(cyc), 32'(2 + 1 + LOCK_CNT));
        wait_high(1, cyc); check("rel1_gap",   32'(cyc), 32'(REL_GAP));
        wait_high(2, cyc); check("run_gap",    32'(cyc), 32'(REL_GAP));
        check("first_run_ce", 32'(ce), 32'b10);
        wait_high(3, cyc); check("first_ce0",  32'(cyc), 32'd3);
        check("aligned_ce",   32'(ce), 32'b11);
        wait_high(3, cyc); check("ce0_period4", 32'(cyc), 32'd4);

        // Ratio change mid-period: old period of 4 completes, then period 2.
        @(negedge clk);
        div_ratio[0 +: DIV_W] = 8'd2;
        wait_high(3, cyc); check("ce0_finish_old", 32'(cyc), 32'd3);
        wait_high(3, cyc); check("ce0_period2a",   32'(cyc), 32'd2);
        wait_high(3, cyc); check("ce0_period2b",   32'(cyc), 32'd2);
        div_ratio[0 +: DIV_W] = 8'd0;
        wait_high(3, cyc); check("ce0_ratio0a",    32'(cyc), 32'd1);
        wait_high(3, cyc); check("ce0_ratio0b",    32'(cyc), 32'd1);
        div_ratio[0 +: DIV_W] = 8'd4;
        repeat (5) @(negedge clk);

        // Loss of lock in RUN: two sync edges then one FSM edge.
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        check("loss_latency_ok", 32'(lock_ok), 32'd1);
        @(negedge clk);
        check("loss_ce",       32'(ce),        32'd0);
        check("loss_ch_rst_n", 32'(ch_rst_n),  32'd0);
        check("loss_lock_ok",  32'(lock_ok),   32'd0);
        check("loss_lost",     32'(lock_lost), 32'd1);
`ifdef CLK_EN_SEQ_LOSS_CNT_EN
        check("loss_cnt_one",  32'(loss_cnt),  32'd1);
`endif
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;
        check("lost_cleared",  32'(lock_lost), 32'd0);
        repeat (3) @(negedge clk);

        // One-cycle glitch at debounce count 10 restarts the full debounce.
        c = 0;
        pll_locked = 1'b1;
        repeat (12) begin @(negedge clk); c++; end
        pll_locked = 1'b0;
        @(negedge clk); c++;
        pll_locked = 1'b1;
        wait_high(0, cyc);
        check("glitch_delay", 32'(cyc < 0 ? -1 : c + cyc), 32'(12 + 3 + LOCK_CNT + 1));

        // Asynchronous reset while in RELEASE: outputs drop with no clock edge.
        #2 rst_n = 1'b0;
        #1 check_all_low("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized phase.
        hold = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            lost_clr = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 39) == 0)
                    div_ratio[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 5));
            if (hold > 0) begin
                hold--;
                pll_locked = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                hold = $urandom_range(0, 3);
                pll_locked = 1'b0;
            end else begin
                pll_locked = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        lost_clr = 1'b0;

`ifdef CLK_EN_SEQ_LOSS_CNT_EN
        // Saturation of the loss counter.
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b1;
            wait_high(2, cyc);
            if (cyc < 0) check("sat_lock_timeout", 32'(cyc), 32'(RUN_N + 2));
            pll_locked = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("loss_cnt_sat", 32'(loss_cnt), 32'd255);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
